// File: rtl/phy_bist_pkg.sv
// Shared definitions for the PHY built-in self-test: LFSR step, checker state
// encodings and default pattern constants.
package phy_bist_pkg;

    localparam int LFSR_MAX_W = 64;

    localparam logic [31:0] DEF_POLY = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED = 32'hFFDD_FFDD;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    // Galois step on a word zero-extended to LFSR_MAX_W; bits above width are cleared.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] w,
        input logic [LFSR_MAX_W-1:0] mask,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] keep;
        keep = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
        return ((w >> 1) ^ (w[0] ? mask : '0)) & keep;
    endfunction

endpackage

// File: rtl/phy_bist_checker.sv
// Self-synchronising PRBS checker: seeds from the first nonzero word, verifies,
// locks, then counts mismatches against a free-running expected sequence.
module phy_bist_checker
    import phy_bist_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] POLY      = DATA_W'(DEF_POLY),
    parameter int                LOCK_CNT  = 4,
    parameter int                ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 chk_en_i,
    input  logic                 err_clr_i,
    input  logic [DATA_W-1:0]    rx_data_i,
    input  logic                 rx_valid_i,
    output logic [1:0]           state_o,
    output logic                 err_pulse_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic [1:0]           state_q, state_d;
    logic [DATA_W-1:0]    exp_q, exp_d, exp_nxt;
    logic [CNT_W-1:0]     match_q, match_d, miss_q, miss_d;
    logic                 pulse_q, pulse_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 hit, inc;

    assign exp_nxt = DATA_W'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(POLY), DATA_W));
    assign hit     = (rx_data_i == exp_nxt);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        inc     = 1'b0;
        if (!chk_en_i) begin
            state_d = ST_IDLE;
            match_d = '0;
            miss_d  = '0;
        end else if (rx_valid_i) begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                // A zero word would seed the LFSR into its lock-up state.
                ST_HUNT: begin
                    if (rx_data_i != '0) begin
                        exp_d   = rx_data_i;
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (hit) begin
                        exp_d   = exp_nxt;
                        match_d = match_q + 1'b1;
                        if (match_q == CNT_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    exp_d = exp_nxt;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        inc     = 1'b1;
                        miss_d  = miss_q + 1'b1;
                        if (miss_q == CNT_W'(LOCK_CNT - 1)) begin
                            state_d = ST_HUNT;
                            miss_d  = '0;
                        end
                    end
                end
            endcase
        end
        if (err_clr_i) begin
            cnt_d = ERR_CNT_W'(inc);
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o     = state_q;
    assign err_pulse_o = pulse_q;
    assign err_count_o = cnt_q;

endmodule

// File: rtl/phy_bist.sv
// PCIe PHY BIST: PRBS word generator striped MSB-first across byte lanes, plus
// the PRBS checker on the reassembled receive word.
module phy_bist
    import phy_bist_pkg::*;
#(
    parameter int                LANES     = 2,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] POLY      = DATA_W'(DEF_POLY),
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED),
    parameter int                LOCK_CNT  = 4,
    parameter int                ERR_CNT_W = 16
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic                 gen_en,
    input  logic                 chk_en,
    input  logic                 err_clr,
    output logic [LANES*8-1:0]   tx_data,
    output logic [LANES-1:0]     tx_valid,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int BPC = DATA_W / (8 * LANES);
    localparam int CW  = (BPC > 1) ? $clog2(BPC) : 1;

    logic [CW-1:0]      cyc_q, cyc_d;
    logic [DATA_W-1:0]  lfsr_q, lfsr_d, shifted;
    logic [LANES*8-1:0] tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               emit, last;
    logic [1:0]         chk_state;

    // gen_en only matters at a word boundary; a started word always completes.
    assign emit    = (cyc_q != '0) || gen_en;
    assign last    = (cyc_q == CW'(BPC - 1));
    assign shifted = lfsr_q << (8 * LANES * cyc_q);

    always_comb begin
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        cyc_d      = cyc_q;
        lfsr_d     = lfsr_q;
        if (emit) begin
            tx_valid_d = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                tx_data_d[8*l +: 8] = shifted[DATA_W-1-8*l -: 8];
            end
            if (last) begin
                cyc_d  = '0;
                lfsr_d = DATA_W'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(POLY), DATA_W));
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            lfsr_q     <= SEED;
            cyc_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            cyc_q      <= cyc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = {LANES{tx_valid_q}};

    phy_bist_checker #(
        .DATA_W    (DATA_W),
        .POLY      (POLY),
        .LOCK_CNT  (LOCK_CNT),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_checker (
        .clk_i       (clk_32f),
        .rst_ni      (reset),
        .chk_en_i    (chk_en),
        .err_clr_i   (err_clr),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .state_o     (chk_state),
        .err_pulse_o (err_pulse),
        .err_count_o (err_count)
    );

    assign locked = (chk_state == ST_LOCKED);

endmodule

// File: doc/phy_bist.md
Name: phy_bist

Overview:
- Parametrised PCIe PHY built-in self-test block: PRBS word generator plus self-synchronising checker.
- Generator stripes DATA_W-bit PRBS words byte-wise across LANES 8-bit lanes, feeding the RX lane inputs.
- Checker compares the reassembled DATA_W-bit RX output against the same PRBS. It reports lock, per-word error pulses and a saturating error count.
- Replaces fixed-vector stimulus with a synthesizable, width/lane-generic pattern source and sink.

Parameters:
- LANES, 2, number of 8-bit byte lanes driven; DATA_W must be a multiple of 8*LANES.
- DATA_W, 32, PRBS word width and RX word width.
- POLY, 32'h8020_0003, Galois LFSR feedback mask (DATA_W bits).
- SEED, 32'hFFDD_FFDD, generator reset word; must be nonzero.
- LOCK_CNT, 4, consecutive matches to lock and consecutive mismatches to drop lock (>=1).
- ERR_CNT_W, 16, error counter width.

Ports:
- clk_32f  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- gen_en  in  1  generator enable, sampled only at word boundaries.
- chk_en  in  1  checker enable.
- err_clr  in  1  synchronous clear of err_count.
- tx_data  out  LANES*8  lane bytes, lane i at bits [8i+7:8i].
- tx_valid  out  LANES  per-lane valid, all bits equal.
- rx_data  in  DATA_W  received word.
- rx_valid  in  1  rx_data qualifier.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word while LOCKED.
- err_count  out  ERR_CNT_W  saturating mismatch count.

Behaviour:
- Reset (reset=0, async):
  - tx_data=0, tx_valid=0, gen LFSR=SEED, byte index=0.
  - Checker state=IDLE, locked=0, err_pulse=0, err_count=0, match/miss counters=0.
- LFSR step: next(w) = (w>>1) ^ (w[0] ? POLY : 0).
- Generator:
  - BPC = DATA_W/(8*LANES) cycles per word.
  - Byte k of a word, MSB first: w[DATA_W-1-8k -: 8]. Byte k goes to lane k%LANES in cycle k/LANES of the word.
  - Outputs are registered; first valid byte appears 1 cycle after gen_en is sampled high at a boundary.
  - LFSR advances on the last cycle of each word.
  - gen_en falling mid-word: the current word completes, then tx_valid=0 and tx_data=0. The LFSR holds its value, so the sequence resumes without a gap.
- Checker FSM (all transitions only on rx_valid=1, except the chk_en exit):
  - IDLE: chk_en=1 -> HUNT.
  - HUNT: exp <= rx_data (self-seed), match=0 -> VERIFY.
  - VERIFY: compare rx_data with next(exp).
    - Match: exp <= next(exp), match++; when match reaches LOCK_CNT -> LOCKED.
    - Mismatch: -> HUNT; the word is discarded, not re-seeded.
  - LOCKED: exp <= next(exp) always; expected sequence is never re-seeded from received data.
    - Mismatch: err_pulse=1 the next cycle, err_count+1 (saturates at all-ones), miss++.
    - Match: miss=0.
    - miss reaching LOCK_CNT -> HUNT, locked=0.
  - chk_en=0 in any state -> IDLE next cycle. locked=0; err_count holds.
  - locked is registered and asserts the cycle after the LOCK_CNT-th match.
  - An all-zero word in HUNT is ignored (stay in HUNT), since a zero seed is a PRBS lock-up.
- err_count:
  - err_clr alone -> 0.
  - err_clr coincident with an error increment -> 1.
  - Saturated counter plus error: stays at max; err_pulse still fires.
- rx_valid=0: no state, exp or counter change; err_pulse=0.

Decomposition:
- Package phy_bist_pkg:
  - lfsr_next function (parametrised by width and mask).
  - Checker state encodings IDLE/HUNT/VERIFY/LOCKED.
  - Default SEED/POLY constants.
- Sub-module phy_bist_checker: checker FSM, expected LFSR and counters.
- The generator stays in the top level.

Test Plan:
- Reset release, gen_en=1, LANES=2:
  - Cycle 1: lane0=FF, lane1=DD. Cycle 2: FF, DD.
  - Cycle 3: FF, CE. Cycle 4: FF, ED (second word FFCE_FFED).
- Loopback of the generator output, reassembled, into rx_data with chk_en=1:
  - locked rises after the seed word plus 4 matches.
  - err_count stays 0 over 1000 words.
- While locked, flip 1 bit of a single word -> exactly one err_pulse, err_count=1, locked stays 1. Following words match because exp is not re-seeded.
- While locked, corrupt 4 consecutive words -> err_count=4, locked falls after the 4th. The checker re-locks after 1+4 clean words.
- err_count at 16'hFFFF plus a new error -> stays FFFF with err_pulse=1. err_clr with a simultaneous error -> 1.
- Assert reset mid-word and mid-LOCKED -> all outputs 0 immediately (async). After release the first word is SEED again.
- Parameter sweep LANES=4, DATA_W=64: 2 cycles per word, byte mapping and loopback lock verified.
